gate_bist_engine: RTL and testbench
===================================

Name: gate_bist_engine

Overview:
- Hardware stimulus/response engine for the basic-gates library.
- Drives every input combination onto an N-input gate under test and samples the gate output.
- Compares each sample against the expected gate function and reports pass/fail, error count and the first failing vector.
- Sits beside a gate instance (AND/OR/XOR/NAND), replacing hand-written stimulus sequences with a self-checking sequential block.

Parameters:
- N_IN, 3, number of gate inputs; vectors 0 .. 2^N_IN-1 are applied.
- SETTLE, 1, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  level sampled in IDLE/DONE; begins a run.
- func_sel  input  2  expected function: 0=AND, 1=OR, 2=XOR (odd parity), 3=NAND.
- stim  output  N_IN  vector driven to the gate under test; bit i maps to gate input i.
- resp  input  1  gate under test output.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next start.
- pass  output  1  valid when done=1; high iff err_count==0.
- err_count  output  ERR_W  number of mismatching vectors; saturating.
- fail_valid  output  1  high once any mismatch has been recorded in the current run.
- fail_vec  output  N_IN  stim value of the first mismatch; valid when fail_valid=1.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n, and takes effect at any rising edge with rst_n=0, including mid-run.
- Reset values: state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0; internal settle counter=0; latched function=AND.
- States:
  - IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 at edge k -> DRIVE.
  - Same edge: stim=0, busy=1, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, func_sel latched.
  - Settle counter loaded with SETTLE-1.
- DRIVE:
  - Counter nonzero -> decrement and stay.
  - Counter zero -> SAMPLE.
  - stim is held constant, so the vector is applied for exactly SETTLE cycles before SAMPLE.
- SAMPLE (one cycle):
  - At the edge leaving SAMPLE, resp is compared to expected(stim, latched func).
  - Expected values: AND = &stim; OR = |stim; XOR = ^stim; NAND = ~&stim.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1.
  - On the first mismatch of the run: fail_vec=stim and fail_valid=1.
  - If stim == 2^N_IN-1 -> DONE, busy=0, done=1, pass = (final err_count==0).
  - Otherwise stim increments by 1, the counter is reloaded with SETTLE-1, and the state returns to DRIVE.
- DONE:
  - Outputs hold.
  - start=1 restarts exactly as from IDLE, with the same same-edge updates.
  - start=0 holds DONE indefinitely.
- Latency: start edge k -> done rises at edge k + 2^N_IN*(SETTLE+1). Defaults: 16 cycles.
- Input handling during a run:
  - start is ignored while busy=1.
  - func_sel changes during a run are ignored.
- stim never wraps within a run; the last vector is all-ones.
- Reset during DRIVE or SAMPLE aborts the run with no done pulse; all outputs take their reset values at that edge.
- start and rst_n=0 at the same edge: reset wins.

Optional Feature:
- Macro: GATE_BIST_RESPMAP_EN.
- Defined:
  - Adds output resp_map, width 2^N_IN.
  - Bit v is set to the sampled resp for vector v at that vector's SAMPLE edge.
  - Cleared to 0 at reset and at each run start.
  - Valid when done=1 (the truth table as observed from the gate under test).
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Good AND gate, func_sel=0, default parameters, start pulsed at edge k:
  - stim steps 0..7, each held 2 cycles.
  - done=1 at edge k+16, pass=1, err_count=0, fail_valid=0.
  - With the macro defined: resp_map=8'h80.
- Gate stuck-at-1, func_sel=0:
  - err_count=7, pass=0, fail_valid=1, fail_vec=3'b000.
  - With the macro defined: resp_map=8'hFF.
- XOR checker against an AND gate (func_sel=2):
  - Mismatches at vectors 1, 2, 4.
  - err_count=3, fail_vec=3'b001, pass=0.
- SETTLE=3, N_IN=2, OR gate, func_sel=1:
  - Each vector held 4 cycles; done exactly 16 cycles after start; pass=1.
- rst_n=0 while stim=5 in DRIVE:
  - Next edge all outputs are at reset values.
  - A new start then gives a full clean 16-cycle run.
- start held high through a run and after done:
  - No restart while busy.
  - Restart occurs at the first edge in DONE with start=1: err_count cleared, done drops, busy=1.
- ERR_W=2, stuck-at-1 gate under AND:
  - err_count saturates at 3, pass=0.

Source files
------------

// File: rtl/gate_bist_engine.sv
// Exhaustive stimulus/response BIST for an N-input basic gate (AND/OR/XOR/NAND).
// Define GATE_BIST_RESPMAP_EN to add the resp_map output (observed truth table).
module gate_bist_engine #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        func_sel,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec
`ifdef GATE_BIST_RESPMAP_EN
  ,
  output logic [(1<<N_IN)-1:0] resp_map
`else
`endif
);

  localparam int              CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic [1:0]       func_q;
  logic             expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    expected = 1'b0;
    unique case (func_q)
      2'd0:    expected = &stim;
      2'd1:    expected = |stim;
      2'd2:    expected = ^stim;
      default: expected = ~&stim;
    endcase
    mismatch = (resp != expected);
    err_next = err_count;
    if (mismatch && (err_count != '1)) err_next = err_count + ERR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      func_q     <= 2'd0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
`ifdef GATE_BIST_RESPMAP_EN
      resp_map   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= CNT_LD;
            func_q     <= func_sel;
            stim       <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
`ifdef GATE_BIST_RESPMAP_EN
            resp_map   <= '0;
`endif
          end
        end
        DRIVE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - CNT_W'(1);
          else                  state      <= SAMPLE;
        end
        SAMPLE: begin
          err_count <= err_next;
          // Only the first mismatch of a run is captured.
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= stim;
          end
`ifdef GATE_BIST_RESPMAP_EN
          resp_map[stim] <= resp;
`endif
          if (stim == '1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            stim       <= stim + N_IN'(1);
            settle_cnt <= CNT_LD;
            state      <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_engine.sv
// Randomized self-checking bench for gate_bist_engine; three instances cover
// default parameters, SETTLE=3/N_IN=2 and ERR_W=2 saturation.
module tb_gate_bist_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance 0: defaults
  logic       start0; logic [1:0] func0; logic [7:0] tt0;
  logic [2:0] stim0;  logic resp0, busy0, done0, pass0, fail_valid0;
  logic [7:0] err0;   logic [2:0] fail_vec0;
  // Instance 1: N_IN=2, SETTLE=3
  logic       start1; logic [1:0] func1; logic [3:0] tt1;
  logic [1:0] stim1;  logic resp1, busy1, done1, pass1, fail_valid1;
  logic [7:0] err1;   logic [1:0] fail_vec1;
  // Instance 2: ERR_W=2
  logic       start2; logic [1:0] func2; logic [7:0] tt2;
  logic [2:0] stim2;  logic resp2, busy2, done2, pass2, fail_valid2;
  logic [1:0] err2;   logic [2:0] fail_vec2;
`ifdef GATE_BIST_RESPMAP_EN
  logic [7:0] resp_map0; logic [3:0] resp_map1; logic [7:0] resp_map2;
`endif

  // Gates under test are modelled as truth tables.
  assign resp0 = tt0[stim0];
  assign resp1 = tt1[stim1];
  assign resp2 = tt2[stim2];

  gate_bist_engine u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .func_sel(func0), .stim(stim0), .resp(resp0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_valid(fail_valid0),
    .fail_vec(fail_vec0)
`ifdef GATE_BIST_RESPMAP_EN
    , .resp_map(resp_map0)
`endif
  );

  gate_bist_engine #(.N_IN(2), .SETTLE(3), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .func_sel(func1), .stim(stim1), .resp(resp1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_valid(fail_valid1),
    .fail_vec(fail_vec1)
`ifdef GATE_BIST_RESPMAP_EN
    , .resp_map(resp_map1)
`endif
  );

  gate_bist_engine #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .func_sel(func2), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_valid(fail_valid2),
    .fail_vec(fail_vec2)
`ifdef GATE_BIST_RESPMAP_EN
    , .resp_map(resp_map2)
`endif
  );

  // Reference gate function from the count of ones in the vector.
  function automatic bit ref_gate(input int f, input int v, input int n);
    int ones;
    ones = $countones(v);
    case (f)
      0:       return ones == n;
      1:       return ones != 0;
      2:       return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  // Full run on instance 0 with per-cycle stim/busy/done and final result checks.
  task automatic run_a(input logic [1:0] f, input logic [7:0] tt, input bit hold, input string name);
    int  exp_err, exp_fv, exp_stim;
    bit  exp_fvld;
    exp_err = 0; exp_fv = 0; exp_fvld = 0;
    for (int v = 0; v < 8; v++) begin
      if (tt[v] != ref_gate(f, v, 3)) begin
        exp_err++;
        if (!exp_fvld) begin exp_fvld = 1; exp_fv = v; end
      end
    end
    func0 = f; tt0 = tt; start0 = 1'b1;
    @(negedge clk);
    if (!hold) start0 = 1'b0;
    func0 = 2'($urandom);
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge clk);
      exp_stim = (j < 16) ? j / 2 : 7;
      n_tests++;
      if (stim0 !== 3'(exp_stim)) begin
        n_fail++; $display("FAIL %s stim j=%0d: got %0d expected %0d", name, j, stim0, exp_stim);
      end
      n_tests++;
      if (busy0 !== (j < 16)) begin
        n_fail++; $display("FAIL %s busy j=%0d: got %b expected %b", name, j, busy0, j < 16);
      end
      n_tests++;
      if (done0 !== (j == 16)) begin
        n_fail++; $display("FAIL %s done j=%0d: got %b expected %b", name, j, done0, j == 16);
      end
    end
    n_tests++;
    if (err0 !== 8'(exp_err)) begin
      n_fail++; $display("FAIL %s err_count: got %0d expected %0d", name, err0, exp_err);
    end
    n_tests++;
    if (pass0 !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s pass: got %b expected %b", name, pass0, exp_err == 0);
    end
    n_tests++;
    if (fail_valid0 !== exp_fvld) begin
      n_fail++; $display("FAIL %s fail_valid: got %b expected %b", name, fail_valid0, exp_fvld);
    end
    if (exp_fvld) begin
      n_tests++;
      if (fail_vec0 !== 3'(exp_fv)) begin
        n_fail++; $display("FAIL %s fail_vec: got %0d expected %0d", name, fail_vec0, exp_fv);
      end
    end
`ifdef GATE_BIST_RESPMAP_EN
    n_tests++;
    if (resp_map0 !== tt) begin
      n_fail++; $display("FAIL %s resp_map: got %h expected %h", name, resp_map0, tt);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start0 = 0; start1 = 0; start2 = 0;
    func0 = 0; func1 = 0; func2 = 0;
    tt0 = 8'h80; tt1 = 4'b1110; tt2 = 8'hFF;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({stim0, busy0, done0, pass0, err0, fail_valid0, fail_vec0} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset inst0: got stim=%0d busy=%b done=%b pass=%b err=%0d fv=%b fvec=%0d expected all zero",
               stim0, busy0, done0, pass0, err0, fail_valid0, fail_vec0);
    end
    n_tests++;
    if ({busy1, done1, err1, stim1, busy2, done2, err2} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset inst1/2: got busy1=%b done1=%b err1=%0d busy2=%b done2=%b err2=%0d expected zero",
               busy1, done1, err1, busy2, done2, err2);
    end
`ifdef GATE_BIST_RESPMAP_EN
    n_tests++;
    if (resp_map0 !== 8'h00) begin
      n_fail++; $display("FAIL reset resp_map: got %h expected 00", resp_map0);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_a(2'd0, 8'h80, 1'b0, "and_good");
    run_a(2'd0, 8'hFF, 1'b0, "and_stuck1");
    run_a(2'd2, 8'h80, 1'b0, "xor_vs_and");
    run_a(2'd3, 8'h7F, 1'b0, "nand_good");
  endtask

  task automatic test_random();
    logic [1:0] f;
    logic [7:0] tt;
    for (int r = 0; r < 8; r++) begin
      f = 2'($urandom_range(0, 3));
      for (int v = 0; v < 8; v++) tt[v] = ref_gate(f, v, 3);
      case ($urandom_range(0, 2))
        0: ;
        1: tt[$urandom_range(0, 7)] ^= 1'b1;
        default: tt = 8'($urandom);
      endcase
      run_a(f, tt, 1'b0, "random");
    end
  endtask

  task automatic test_mid_reset();
    func0 = 2'd0; tt0 = 8'h80; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (stim0 !== 3'd5 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset pre: got stim=%0d busy=%b expected stim=5 busy=1", stim0, busy0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({stim0, busy0, done0, pass0, err0, fail_valid0, fail_vec0} !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset post: got stim=%0d busy=%b done=%b err=%0d expected all zero",
               stim0, busy0, done0, err0);
    end
    start0 = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0 || stim0 !== 3'd0) begin
      n_fail++; $display("FAIL reset_vs_start: got busy=%b stim=%0d expected busy=0 stim=0", busy0, stim0);
    end
    rst_n = 1'b1; start0 = 1'b0;
    @(negedge clk);
    run_a(2'd0, 8'h80, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_a(2'd0, 8'hFF, 1'b1, "start_held");
    func0 = 2'd0;
    @(negedge clk);
    n_tests++;
    if (done0 !== 1'b0 || busy0 !== 1'b1 || err0 !== 8'd0 || stim0 !== 3'd0 || fail_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL restart: got done=%b busy=%b err=%0d stim=%0d fv=%b expected 0 1 0 0 0",
               done0, busy0, err0, stim0, fail_valid0);
    end
    start0 = 1'b0;
    repeat (16) @(negedge clk);
    n_tests++;
    if (done0 !== 1'b1 || err0 !== 8'd7 || pass0 !== 1'b0 || fail_vec0 !== 3'd0) begin
      n_fail++;
      $display("FAIL restart_run: got done=%b err=%0d pass=%b fvec=%0d expected 1 7 0 0",
               done0, err0, pass0, fail_vec0);
    end
  endtask

  // SETTLE=3, N_IN=2: every vector is held 4 cycles, done 16 cycles after start.
  task automatic test_settle(input logic [1:0] f, input logic [3:0] tt, input string name);
    int exp_err, exp_stim;
    exp_err = 0;
    for (int v = 0; v < 4; v++) if (tt[v] != ref_gate(f, v, 2)) exp_err++;
    func1 = f; tt1 = tt; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    func1 = 2'($urandom);
    for (int j = 0; j <= 16; j++) begin
      if (j > 0) @(negedge clk);
      exp_stim = (j < 16) ? j / 4 : 3;
      n_tests++;
      if (stim1 !== 2'(exp_stim) || done1 !== (j == 16) || busy1 !== (j < 16)) begin
        n_fail++;
        $display("FAIL %s j=%0d: got stim=%0d done=%b busy=%b expected stim=%0d done=%b busy=%b",
                 name, j, stim1, done1, busy1, exp_stim, j == 16, j < 16);
      end
    end
    n_tests++;
    if (err1 !== 8'(exp_err) || pass1 !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s result: got err=%0d pass=%b expected err=%0d", name, err1, pass1, exp_err);
    end
`ifdef GATE_BIST_RESPMAP_EN
    n_tests++;
    if (resp_map1 !== tt) begin
      n_fail++; $display("FAIL %s resp_map: got %h expected %h", name, resp_map1, tt);
    end
`endif
  endtask

  // ERR_W=2: error counter saturates at 3.
  task automatic test_saturate(input logic [1:0] f, input logic [7:0] tt, input string name);
    int exp_err, exp_fv;
    exp_err = 0; exp_fv = -1;
    for (int v = 0; v < 8; v++) begin
      if (tt[v] != ref_gate(f, v, 3)) begin
        if (exp_fv < 0) exp_fv = v;
        exp_err++;
      end
    end
    if (exp_err > 3) exp_err = 3;
    func2 = f; tt2 = tt; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 40 && !done2; c++) @(negedge clk);
    n_tests++;
    if (done2 !== 1'b1) begin
      n_fail++; $display("FAIL %s timeout: got done=%b expected 1", name, done2);
    end
    n_tests++;
    if (err2 !== 2'(exp_err) || pass2 !== (exp_err == 0)) begin
      n_fail++; $display("FAIL %s result: got err=%0d pass=%b expected err=%0d", name, err2, pass2, exp_err);
    end
    if (exp_fv >= 0) begin
      n_tests++;
      if (fail_vec2 !== 3'(exp_fv) || fail_valid2 !== 1'b1) begin
        n_fail++; $display("FAIL %s fail_vec: got %0d expected %0d", name, fail_vec2, exp_fv);
      end
    end
`ifdef GATE_BIST_RESPMAP_EN
    n_tests++;
    if (resp_map2 !== tt) begin
      n_fail++; $display("FAIL %s resp_map: got %h expected %h", name, resp_map2, tt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mid_reset();
    test_back_to_back();
    test_settle(2'd1, 4'b1110, "settle_or");
    for (int r = 0; r < 3; r++) test_settle(2'($urandom_range(0, 3)), 4'($urandom), "settle_rand");
    test_saturate(2'd0, 8'hFF, "saturate");
    for (int r = 0; r < 3; r++) test_saturate(2'($urandom_range(0, 3)), 8'($urandom), "sat_rand");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
